// File: rtl/baud_gen_prog_if.sv
// Control and strobe bundle between a UART and its baud generator.
// Latency: none, wires only.
// Backpressure: none; strobes are single-cycle pulses with no handshake.
interface baud_gen_prog_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              rx_resync;
  logic              div_pending;
  logic              tx_enb;
  logic              rx_enb;
  logic              rx_mid;

  // UART side: programs the divisor and consumes the strobes
  modport master (
    output en, div_int, div_frac, div_load, rx_resync,
    input  div_pending, tx_enb, rx_enb, rx_mid
  );

  // generator side
  modport slave (
    input  en, div_int, div_frac, div_load, rx_resync,
    output div_pending, tx_enb, rx_enb, rx_mid
  );
endinterface

// File: rtl/baud_gen_prog.sv
// Programmable fractional baud generator: TX baud strobe, RX oversample and bit-centre strobes.
// Latency: all outputs registered; a strobe appears L edges after its period starts.
// Backpressure: none; en=0 freezes all timing, a new divisor waits for the next base period boundary.
module baud_gen_prog #(
  parameter int OSR            = 16,
  parameter int DIV_W          = 16,
  parameter int FRAC_W         = 4,
  parameter int RESET_DIV_INT  = 325,
  parameter int RESET_DIV_FRAC = 8
) (
  input  logic           clk,
  input  logic           rst,
  baud_gen_prog_if.slave bus
);

  // period length can reach 2^DIV_W (max integer plus a carry)
  localparam int CNT_W = DIV_W + 1;
  localparam int OS_W  = $clog2(OSR);

  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RESET_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_DIV_FRAC);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OSR / 2 - 1);

  // Length of the current period: integer part (floored at 2 so strobes
  // never touch) plus the carry out of the fraction accumulator.
  function automatic logic [CNT_W-1:0] period_len(
    input logic [DIV_W-1:0]  dint,
    input logic [FRAC_W-1:0] dfrac,
    input logic [FRAC_W-1:0] acc
  );
    logic [FRAC_W:0]  fsum;
    logic [CNT_W-1:0] ipart;
    fsum  = {1'b0, acc} + {1'b0, dfrac};
    ipart = (dint < DIV_W'(2)) ? CNT_W'(2) : {1'b0, dint};
    return ipart + CNT_W'(fsum[FRAC_W]);
  endfunction

  // active / shadow divisor
  logic [DIV_W-1:0]  act_int, shd_int, nxt_int;
  logic [FRAC_W-1:0] act_frac, shd_frac, nxt_frac;
  logic              pend_q, swap_q;

  // each engine latches its divisor at period start so that an in-flight
  // period always finishes with the length it began with
  logic [DIV_W-1:0]  base_int, rx_int;
  logic [FRAC_W-1:0] base_frac, rx_frac;
  logic [FRAC_W-1:0] base_acc, rx_acc;
  logic [CNT_W-1:0]  base_cnt, rx_cnt;
  logic [CNT_W-1:0]  base_len, rx_len;
  logic [OS_W-1:0]   tx_os_cnt, rx_os_cnt;
  logic              base_hit, rx_hit, swap;
  logic              tx_q, rx_q, mid_q;

  // end-of-period detection and the divisor handed to periods starting now
  always_comb begin
    base_len = period_len(base_int, base_frac, base_acc);
    rx_len   = period_len(rx_int, rx_frac, rx_acc);
    base_hit = bus.en && (base_cnt + CNT_W'(1) == base_len);
    rx_hit   = bus.en && !bus.rx_resync && (rx_cnt + CNT_W'(1) == rx_len);
    swap     = base_hit && pend_q;
    nxt_int  = swap ? shd_int  : act_int;
    nxt_frac = swap ? shd_frac : act_frac;
  end

  // Divisor shadowing: the swap happens on a base strobe; pending drops one
  // cycle later unless a fresh load arrived meanwhile (that one waits).
  always_ff @(posedge clk) begin
    if (rst) begin
      act_int  <= RST_INT;
      act_frac <= RST_FRAC;
      shd_int  <= '0;
      shd_frac <= '0;
      pend_q   <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      if (swap) begin
        act_int  <= shd_int;
        act_frac <= shd_frac;
      end
      if (bus.div_load) begin
        shd_int  <= bus.div_int;
        shd_frac <= bus.div_frac;
      end
      if (bus.div_load)
        pend_q <= 1'b1;
      else if (swap_q)
        pend_q <= 1'b0;
      swap_q <= swap && !bus.div_load;
    end
  end

  // Free-running base engine and the TX divide-by-OSR
  always_ff @(posedge clk) begin
    if (rst) begin
      base_cnt  <= '0;
      base_acc  <= '0;
      base_int  <= RST_INT;
      base_frac <= RST_FRAC;
      tx_os_cnt <= '0;
      tx_q      <= 1'b0;
    end else begin
      tx_q <= base_hit && (tx_os_cnt == OS_LAST);
      if (base_hit) begin
        base_cnt  <= '0;
        base_acc  <= base_acc + base_frac;
        base_int  <= nxt_int;
        base_frac <= nxt_frac;
        tx_os_cnt <= (tx_os_cnt == OS_LAST) ? '0 : tx_os_cnt + OS_W'(1);
      end else if (bus.en) begin
        base_cnt <= base_cnt + CNT_W'(1);
      end
    end
  end

  // RX engine: same divisor, restarted by start-bit detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt    <= '0;
      rx_acc    <= '0;
      rx_int    <= RST_INT;
      rx_frac   <= RST_FRAC;
      rx_os_cnt <= '0;
      rx_q      <= 1'b0;
      mid_q     <= 1'b0;
    end else if (bus.rx_resync) begin
      rx_cnt    <= '0;
      rx_acc    <= '0;
      rx_int    <= nxt_int;
      rx_frac   <= nxt_frac;
      rx_os_cnt <= '0;
      rx_q      <= 1'b0;
      mid_q     <= 1'b0;
    end else begin
      rx_q  <= rx_hit;
      mid_q <= rx_hit && (rx_os_cnt == OS_MID);
      if (rx_hit) begin
        rx_cnt    <= '0;
        rx_acc    <= rx_acc + rx_frac;
        rx_int    <= nxt_int;
        rx_frac   <= nxt_frac;
        rx_os_cnt <= (rx_os_cnt == OS_LAST) ? '0 : rx_os_cnt + OS_W'(1);
      end else if (bus.en) begin
        rx_cnt <= rx_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.div_pending = pend_q;
  assign bus.tx_enb      = tx_q;
  assign bus.rx_enb      = rx_q;
  assign bus.rx_mid      = mid_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Scoreboard bench for baud_gen_prog: a timestamp model predicts strobe cycles.
// Latency: expectations are tagged with the cycle they must appear in.
// Backpressure: none; stimulus drives en/div_load/rx_resync with random timing.
module tb_baud_gen_prog;
  localparam int OSR    = 16;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int R_INT  = 325;
  localparam int R_FRAC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  baud_gen_prog_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

  baud_gen_prog #(
    .OSR(OSR), .DIV_W(DIV_W), .FRAC_W(FRAC_W),
    .RESET_DIV_INT(R_INT), .RESET_DIV_FRAC(R_FRAC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  // expected strobe cycles per output: 0 tx_enb, 1 rx_enb, 2 rx_mid
  int unsigned q_ev[3][$];
  bit          q_pend[$];

  // model state: strobes are predicted as absolute counts of enabled edges
  int unsigned en_time, base_at, rx_at, k_base, j_rx;
  int m_act_int, m_act_frac, m_shd_int, m_shd_frac;
  int b_acc, b_frac, r_acc, r_frac;
  bit m_pend, m_swap_prev, bh, rh, sw;

  function automatic int plen(input int dint, input int dfrac, input int acc);
    return ((dint < 2) ? 2 : dint) + (((acc + dfrac) >= (1 << FRAC_W)) ? 1 : 0);
  endfunction

  // reference model, evaluated with the inputs sampled at each edge
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      en_time = 0; k_base = 0; j_rx = 0;
      m_act_int = R_INT; m_act_frac = R_FRAC; m_shd_int = 0; m_shd_frac = 0;
      m_pend = 0; m_swap_prev = 0;
      b_acc = 0; r_acc = 0; b_frac = R_FRAC; r_frac = R_FRAC;
      base_at = plen(R_INT, R_FRAC, 0);
      rx_at = base_at;
    end else begin
      if (bus.en) en_time++;
      bh = bus.en && (en_time == base_at);
      rh = bus.en && !bus.rx_resync && (en_time == rx_at);
      sw = bh && m_pend;
      if (sw) begin
        m_act_int = m_shd_int;
        m_act_frac = m_shd_frac;
      end
      if (bh) begin
        k_base++;
        if (k_base % OSR == 0) q_ev[0].push_back(cyc);
        b_acc = (b_acc + b_frac) % (1 << FRAC_W);
        b_frac = m_act_frac;
        base_at = en_time + plen(m_act_int, b_frac, b_acc);
      end
      if (bus.rx_resync) begin
        j_rx = 0; r_acc = 0; r_frac = m_act_frac;
        rx_at = en_time + plen(m_act_int, r_frac, 0);
      end else if (rh) begin
        j_rx++;
        q_ev[1].push_back(cyc);
        if (j_rx % OSR == OSR / 2) q_ev[2].push_back(cyc);
        r_acc = (r_acc + r_frac) % (1 << FRAC_W);
        r_frac = m_act_frac;
        rx_at = en_time + plen(m_act_int, r_frac, r_acc);
      end
      if (bus.div_load) begin
        m_shd_int = int'(bus.div_int);
        m_shd_frac = int'(bus.div_frac);
        m_pend = 1;
      end else if (m_swap_prev) begin
        m_pend = 0;
      end
      m_swap_prev = sw && !bus.div_load;
    end
    q_pend.push_back(m_pend);
  end

  task automatic report(input string name, input logic act, input logic exp);
    fails++;
    if (fails <= 30)
      $display("FAIL %s cycle %0d: got %b, wanted %b", name, cyc, act, exp);
  endtask

  // compare one strobe output against its queue of expected cycles
  task automatic check_ev(input int kind, input string name, input logic v);
    while (q_ev[kind].size() > 0 && q_ev[kind][0] < cyc) begin
      tests++;
      report(name, 1'b0, 1'b1);
      void'(q_ev[kind].pop_front());
    end
    if (v !== 1'b0) begin
      tests++;
      if (v === 1'b1 && q_ev[kind].size() > 0 && q_ev[kind][0] == cyc)
        void'(q_ev[kind].pop_front());
      else
        report(name, v, 1'b0);
    end else if (q_ev[kind].size() > 0 && q_ev[kind][0] == cyc) begin
      tests++;
      report(name, v, 1'b1);
      void'(q_ev[kind].pop_front());
    end
  endtask

  // monitor: sample outputs mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      check_ev(0, "tx_enb", bus.tx_enb);
      check_ev(1, "rx_enb", bus.rx_enb);
      check_ev(2, "rx_mid", bus.rx_mid);
      tests++;
      if (q_pend.size() == 0)
        report("div_pending_queue", bus.div_pending, 1'b0);
      else begin
        if (bus.div_pending !== q_pend[0])
          report("div_pending", bus.div_pending, q_pend[0]);
        void'(q_pend.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.div_load  = 1'b0;
    bus.rx_resync = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int i, input int f);
    bus.div_int  = DIV_W'(i);
    bus.div_frac = FRAC_W'(f);
    bus.div_load = 1'b1;
    tick();
  endtask

  task automatic resync();
    bus.rx_resync = 1'b1;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // stimulus
  initial begin
    bus.en = 1'b1; bus.div_int = '0; bus.div_frac = '0;
    bus.div_load = 1'b0; bus.rx_resync = 1'b0;
    run(3);
    rst = 1'b0;
    // defaults: alternating 325/326, tx every 16 base strobes
    run(6000);
    // mid-period load of 10/0
    run($urandom_range(50, 300));
    load(10, 0);
    run(400);
    // resync at arbitrary points
    for (int i = 0; i < 3; i++) begin
      run($urandom_range(3, 40));
      resync();
      run(200);
    end
    // degenerate and fractional divisors
    load(0, 0);  run(100);
    load(1, 0);  run(100);
    load(4, 15); run(300);
    // en held low mid-period
    load(30, 0);
    run(100 + $urandom_range(1, 20));
    bus.en = 1'b0;
    run(50);
    resync();
    run(10);
    bus.en = 1'b1;
    run(200);
    // reset while a new divisor is pending
    run(15);
    load(50, 3);
    pulse_rst();
    run(5300);
    // simultaneous load and resync, plus back-to-back loads
    bus.div_int = DIV_W'(12); bus.div_frac = FRAC_W'(5);
    bus.div_load = 1'b1; bus.rx_resync = 1'b1;
    tick();
    run(5);
    load(7, 9);
    load(9, 2);
    run(300);
    // random soak
    for (int i = 0; i < 15000; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) begin
        bus.div_int = DIV_W'($urandom_range(0, 24));
        bus.div_frac = FRAC_W'($urandom_range(0, 15));
        bus.div_load = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) bus.rx_resync = 1'b1;
      rst = ($urandom_range(0, 4999) == 0);
      tick();
    end
    rst = 1'b0;
    bus.en = 1'b1;
    run(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard stop if something stalls the stimulus
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
